// File: rtl/audio_adc_rx.sv
// I2S-mode ADC serial receiver: synchronizes the codec's bclk/adclrc/adcdat lines into sys_clk
// and deserializes MSB-first left/right words into a coherent parallel sample pair.
module audio_adc_rx #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             bclk,
  input  logic             adclrc,
  input  logic             adcdat,
  output logic [WIDTH-1:0] data_left,
  output logic [WIDTH-1:0] data_right,
  output logic             sample_valid,
  output logic             locked,
  output logic             frame_err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StUnsync, StShift, StWait} state_e;

  // Reset asserts asynchronously and releases on a sys_clk edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // All three pins go through equal-depth chains so data stays aligned with the bclk edge.
  logic [SYNC_STAGES-1:0] bclk_sync_q, lrc_sync_q, dat_sync_q;
  logic                   bclk_prev_q;
  logic                   bclk_s, lrc_s, dat_s, bit_tick;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync_q <= '0;
      lrc_sync_q  <= '0;
      dat_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
      lrc_sync_q  <= {lrc_sync_q[SYNC_STAGES-2:0], adclrc};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], adcdat};
      bclk_prev_q <= bclk_s;
    end
  end

  assign bclk_s   = bclk_sync_q[SYNC_STAGES-1];
  assign lrc_s    = lrc_sync_q[SYNC_STAGES-1];
  assign dat_s    = dat_sync_q[SYNC_STAGES-1];
  assign bit_tick = bclk_s & ~bclk_prev_q;

  state_e            state_q, state_d;
  logic              chan_q, chan_d;
  logic              lrc_prev_q, lrc_prev_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  left_hold_q, left_hold_d;
  logic [WIDTH-1:0]  data_left_q, data_left_d;
  logic [WIDTH-1:0]  data_right_q, data_right_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              locked_q, locked_d;
  logic              slot_start, commit;
  logic [WIDTH-1:0]  word;
  int unsigned       pad;

  assign slot_start = bit_tick && (lrc_s != lrc_prev_q);

  // The slot-start tick carries the previous word's last bit, so it only re-arms the shifter.
  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    lrc_prev_d   = lrc_prev_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    left_hold_d  = left_hold_q;
    data_left_d  = data_left_q;
    data_right_d = data_right_q;
    locked_d     = locked_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    commit       = 1'b0;
    word         = '0;
    pad          = 0;

    if (bit_tick) begin
      lrc_prev_d = lrc_s;
      case (state_q)
        StUnsync: begin
          if (slot_start && !lrc_s) begin
            locked_d  = 1'b1;
            chan_d    = 1'b0;
            shift_d   = '0;
            bit_cnt_d = '0;
            state_d   = StShift;
          end
        end
        StShift: begin
          if (slot_start) begin
            err_d = 1'b1;
            if (bit_cnt_q == '0) begin
              // A slot with no data bits was a glitch: the same channel has started twice.
              locked_d = 1'b0;
              state_d  = StUnsync;
            end else begin
              pad       = WIDTH - 32'(bit_cnt_q);
              word      = shift_q << pad;
              commit    = 1'b1;
              chan_d    = lrc_s;
              shift_d   = '0;
              bit_cnt_d = '0;
            end
          end else begin
            shift_d   = {shift_q[WIDTH-2:0], dat_s};
            bit_cnt_d = bit_cnt_q + CntW'(1);
            if (bit_cnt_q == CntW'(WIDTH - 1)) begin
              word    = {shift_q[WIDTH-2:0], dat_s};
              commit  = 1'b1;
              state_d = StWait;
            end
          end
        end
        StWait: begin
          if (slot_start) begin
            chan_d    = lrc_s;
            shift_d   = '0;
            bit_cnt_d = '0;
            state_d   = StShift;
          end
        end
        default: state_d = StUnsync;
      endcase
    end

    // Outputs only move on a right commit so left/right always belong to the same frame.
    if (commit) begin
      if (chan_q) begin
        data_right_d = word;
        data_left_d  = left_hold_q;
        valid_d      = 1'b1;
      end else begin
        left_hold_d = word;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StUnsync;
      chan_q       <= 1'b0;
      lrc_prev_q   <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      left_hold_q  <= '0;
      data_left_q  <= '0;
      data_right_q <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      lrc_prev_q   <= lrc_prev_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      left_hold_q  <= left_hold_d;
      data_left_q  <= data_left_d;
      data_right_q <= data_right_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      locked_q     <= locked_d;
    end
  end

  assign data_left    = data_left_q;
  assign data_right   = data_right_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Self-checking bench for audio_adc_rx: directed frame table, corner sequences and randomized
// frames at 4x oversampling checked against a slot-level reference model.
module tb_audio_adc_rx;

  localparam int W = 24;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n;
  logic         bclk, adclrc, adcdat;
  logic [W-1:0] data_left, data_right;
  logic         sample_valid, locked, frame_err;

  always #5 sys_clk = ~sys_clk;

  audio_adc_rx #(
    .WIDTH      (W),
    .SYNC_STAGES(2)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .bclk        (bclk),
    .adclrc      (adclrc),
    .adcdat      (adcdat),
    .data_left   (data_left),
    .data_right  (data_right),
    .sample_valid(sample_valid),
    .locked      (locked),
    .frame_err   (frame_err)
  );

  // Monitor: records every output pair and the frame_err pulses seen since the previous pair.
  logic [W-1:0] got_l[$], got_r[$];
  int           got_e[$];
  int           err_acc = 0, err_total = 0, dbl = 0;
  logic         prev_valid = 1'b0;

  always @(negedge sys_clk) begin
    if (frame_err) begin
      err_acc++;
      err_total++;
    end
    if (sample_valid) begin
      got_l.push_back(data_left);
      got_r.push_back(data_right);
      got_e.push_back(err_acc);
      err_acc = 0;
      if (prev_valid) dbl++;
    end
    prev_valid = sample_valid;
  end

  int checks = 0, errors = 0;
  int half_ns = 40;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input logic lrc, input logic dat);
    bclk = 1'b0; adclrc = lrc; adcdat = dat;
    #(half_ns);
    bclk = 1'b1;
    #(half_ns);
  endtask

  // adclrc pulses high for half a bclk around one rising edge.
  task automatic glitch_tick();
    bclk = 1'b0; adclrc = 1'b0; adcdat = 1'b0;
    #(half_ns / 2); adclrc = 1'b1;
    #(half_ns / 2); bclk = 1'b1;
    #(half_ns / 2); adclrc = 1'b0;
    #(half_ns / 2);
  endtask

  // I2S slot: tick 0 is filler, ticks 1..W carry the word MSB first, the rest is filler.
  task automatic slot(input logic lrc, input logic [W-1:0] w, input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      if (i >= 1 && i <= W) b = w[W-i];
      else b = 1'($urandom_range(0, 1));
      tick(lrc, b);
    end
  endtask

  // A slot of n ticks delivers n-1 data bits; a short word keeps its top bits, the rest zero.
  function automatic logic [W-1:0] model_word(input logic [W-1:0] w, input int n);
    logic [W-1:0] mask;
    if (n - 1 >= W) return w;
    mask = '1;
    mask = mask << (W - (n - 1));
    return w & mask;
  endfunction

  function automatic int model_err(input int n);
    return (n - 1 < W) ? 1 : 0;
  endfunction

  typedef struct {
    logic [W-1:0] lw, rw;
    int           ln, rn;
    logic [W-1:0] el, er;
    int           ee;
  } vec_t;

  vec_t         vecs[5];
  logic [W-1:0] exp_l[$], exp_r[$];
  int           exp_e[$];
  int           base, errs0;
  int           ln, rn;
  logic [W-1:0] lw, rw;

  initial begin
    vecs[0] = '{24'hA5C3F0, 24'h0F1E2D, 128, 128, 24'hA5C3F0, 24'h0F1E2D, 0};
    vecs[1] = '{24'hFFFFFF, 24'h123456, 13,  32,  24'hFFF000, 24'h123456, 1};
    vecs[2] = '{24'h800001, 24'hF0F0F0, 25,  5,   24'h800001, 24'hF00000, 1};
    vecs[3] = '{24'h000000, 24'hFFFFFF, 26,  30,  24'h000000, 24'hFFFFFF, 0};
    vecs[4] = '{24'hFFFFFF, 24'h7FFFFF, 2,   40,  24'h800000, 24'h7FFFFF, 1};

    // Reset values, with the pins sitting mid right slot.
    sys_rst_n = 1'b0; bclk = 1'b0; adclrc = 1'b1; adcdat = 1'b1;
    #103;
    check("reset data_left", data_left, 0);
    check("reset data_right", data_right, 0);
    check("reset sample_valid", sample_valid, 0);
    check("reset locked", locked, 0);
    check("reset frame_err", frame_err, 0);
    sys_rst_n = 1'b1;
    #57;

    // Stimulus starting mid right slot must not lock.
    for (int i = 0; i < 10; i++) tick(1'b1, 1'($urandom_range(0, 1)));
    check("midslot locked", locked, 0);
    check("midslot no valid", got_l.size(), 0);

    // Directed frame table; the trailing left slot closes the last right slot.
    base = got_l.size();
    for (int i = 0; i < 5; i++) begin
      slot(1'b0, vecs[i].lw, vecs[i].ln);
      slot(1'b1, vecs[i].rw, vecs[i].rn);
    end
    slot(1'b0, 24'h123456, 10);
    check("table pulse count", got_l.size() - base, 5);
    check("table locked", locked, 1);
    for (int i = 0; i < 5; i++) begin
      if (base + i < got_l.size()) begin
        check($sformatf("row%0d left", i), got_l[base+i], vecs[i].el);
        check($sformatf("row%0d right", i), got_r[base+i], vecs[i].er);
        check($sformatf("row%0d frame_err", i), got_e[base+i], vecs[i].ee);
      end
    end

    // adclrc glitch inside a left slot: error, unlock, outputs hold, re-lock on next fall.
    base = got_l.size();
    errs0 = err_total;
    glitch_tick();
    for (int i = 0; i < 15; i++) tick(1'b0, 1'($urandom_range(0, 1)));
    check("glitch frame_err seen", err_total > errs0, 1);
    check("glitch locked", locked, 0);
    check("glitch hold left", data_left, vecs[4].el);
    check("glitch hold right", data_right, vecs[4].er);
    slot(1'b1, 24'h555555, 30);
    check("glitch no valid", got_l.size() - base, 0);
    check("glitch still unlocked", locked, 0);
    slot(1'b0, 24'h13579B, 30);
    slot(1'b1, 24'h2468AC, 30);
    check("relock locked", locked, 1);
    check("relock pulse count", got_l.size() - base, 1);
    if (got_l.size() > base) begin
      check("relock left", got_l[base], 24'h13579B);
      check("relock right", got_r[base], 24'h2468AC);
    end

    // Asynchronous reset mid right slot.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'($urandom_range(0, 1)));
    #3 sys_rst_n = 1'b0;
    #1;
    check("midreset data_left", data_left, 0);
    check("midreset data_right", data_right, 0);
    check("midreset locked", locked, 0);
    check("midreset sample_valid", sample_valid, 0);
    #17 sys_rst_n = 1'b1;
    base = got_l.size();
    for (int i = 0; i < 20; i++) tick(1'b1, 1'($urandom_range(0, 1)));
    check("postreset no valid", got_l.size() - base, 0);
    check("postreset unlocked", locked, 0);
    slot(1'b0, 24'hCAFE01, 30);
    slot(1'b1, 24'hBEEF02, 30);
    check("postreset pulse count", got_l.size() - base, 1);
    if (got_l.size() > base) begin
      check("postreset left", got_l[base], 24'hCAFE01);
      check("postreset right", got_r[base], 24'hBEEF02);
    end

    // Random frames at exactly 4x oversampling with the bclk phase drifting each frame.
    half_ns = 20;
    base = got_l.size();
    for (int f = 0; f < 150; f++) begin
      lw = W'($urandom);
      rw = W'($urandom);
      ln = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, W)) : int'($urandom_range(W + 1, 32));
      rn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, W)) : int'($urandom_range(W + 1, 32));
      exp_l.push_back(model_word(lw, ln));
      exp_r.push_back(model_word(rw, rn));
      exp_e.push_back(model_err(ln) + model_err(rn));
      #($urandom_range(1, 9));
      slot(1'b0, lw, ln);
      slot(1'b1, rw, rn);
    end
    slot(1'b0, 24'h0, 30);
    check("random pulse count", got_l.size() - base, exp_l.size());
    for (int i = 0; i < exp_l.size(); i++) begin
      if (base + i < got_l.size()) begin
        check($sformatf("random frame %0d", i), {got_l[base+i], got_r[base+i], 8'(got_e[base+i])},
              {exp_l[i], exp_r[i], 8'(exp_e[i])});
      end
    end
    check("single-cycle sample_valid", dbl, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
